// File: rtl/capsense_event.sv
`default_nettype none
// ============================================================================
// Module   : capsense_event
// Brief    : Per-button debounce, press/release/long-press event generation
//            and FIFO serialisation of capsense poll results.
//            Long-press logic is built only with CAPSENSE_EVT_LONGPRESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module capsense_event #(
    parameter  int N          = 4,
    parameter  int DEBOUNCE   = 3,
    parameter  int LONG_TICKS = 20,
    parameter  int DEPTH      = 4,
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sample_stb_i,
    input  logic [N-1:0]     buttons_i,
    input  logic             tick_i,
    output logic [N-1:0]     state_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [IDX_W-1:0] evt_btn_o,
    output logic [1:0]       evt_kind_o,
    output logic             overflow_o
);

    localparam int            c_aw       = $clog2(DEPTH);
    localparam int            c_ptr_w    = c_aw + 1;
    localparam logic [3:0]    c_deb      = 4'(DEBOUNCE);
    localparam logic [1:0]    c_kind_rel = 2'd0;
    localparam logic [1:0]    c_kind_prs = 2'd1;
    localparam logic [1:0]    c_kind_lng = 2'd2;
    localparam logic [c_ptr_w-1:0] c_full_pat = c_ptr_w'(1) << c_aw;

    logic [N-1:0]       r_state;
    logic [N-1:0]       r_pend_v;
    logic [1:0]         r_pend_k [N];
    logic               r_ovf;

    logic [N-1:0]       w_flip;
    logic [N-1:0]       w_long;
    logic [N-1:0]       w_new_v;
    logic [1:0]         w_new_k  [N];
    logic [N-1:0]       w_take;
    logic [N-1:0]       w_lost;

    logic [IDX_W-1:0]   w_sel;
    logic [1:0]         w_sel_k;
    logic               w_sel_v;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;

    logic [IDX_W+1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [IDX_W+1:0]   w_head;

    // ------------------------------------------------------------------
    // Per-button debounce and (optionally) long-press timing
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_btn
        logic [3:0] r_deb_cnt;
        logic [3:0] w_deb_inc;
        logic       w_disagree;

        assign w_deb_inc  = r_deb_cnt + 4'd1;
        assign w_disagree = buttons_i[i] != r_state[i];
        assign w_flip[i]  = sample_stb_i && w_disagree && (w_deb_inc == c_deb);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_deb_cnt <= 4'd0;
            end else if (sample_stb_i) begin
                if (!w_disagree || w_flip[i]) begin
                    r_deb_cnt <= 4'd0;
                end else begin
                    r_deb_cnt <= w_deb_inc;
                end
            end
        end

`ifdef CAPSENSE_EVT_LONGPRESS_EN
        localparam logic [7:0] c_long    = 8'(LONG_TICKS);
        localparam logic [7:0] c_long_m1 = 8'(LONG_TICKS - 1);
        logic [7:0] r_long_cnt;

        // Saturation at c_long keeps this to one long event per press.
        assign w_long[i] = r_state[i] && tick_i && (r_long_cnt == c_long_m1);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_long_cnt <= 8'd0;
            end else if (w_flip[i]) begin
                r_long_cnt <= 8'd0;
            end else if (r_state[i] && tick_i && (r_long_cnt != c_long)) begin
                r_long_cnt <= r_long_cnt + 8'd1;
            end
        end
`else
        assign w_long[i] = 1'b0;
`endif

        assign w_new_v[i] = w_flip[i] || w_long[i];
        assign w_new_k[i] = w_flip[i] ? (r_state[i] ? c_kind_rel : c_kind_prs) : c_kind_lng;
        assign w_take[i]  = w_push && (w_sel == IDX_W'(i));
        // A flip hides a coincident long event; either way something is lost.
        assign w_lost[i]  = (w_new_v[i] && r_pend_v[i] && !w_take[i]) ||
                            (w_flip[i] && w_long[i]);
    end

`ifndef CAPSENSE_EVT_LONGPRESS_EN
    wire w_unused_tick = tick_i;
    localparam int c_unused_long = LONG_TICKS;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= '0;
        end else begin
            r_state <= r_state ^ w_flip;
        end
    end

    // ------------------------------------------------------------------
    // Pending slots and lowest-index serialiser
    // ------------------------------------------------------------------
    always_comb begin
        w_sel   = '0;
        w_sel_k = c_kind_rel;
        w_sel_v = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (r_pend_v[j]) begin
                w_sel   = IDX_W'(j);
                w_sel_k = r_pend_k[j];
                w_sel_v = 1'b1;
            end
        end
    end

    assign w_push = w_sel_v && (!w_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend_v <= '0;
            r_ovf    <= 1'b0;
            for (int j = 0; j < N; j++) begin
                r_pend_k[j] <= c_kind_rel;
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                if (w_new_v[j]) begin
                    r_pend_v[j] <= 1'b1;
                    r_pend_k[j] <= w_new_k[j];
                end else if (w_take[j]) begin
                    r_pend_v[j] <= 1'b0;
                end
            end
            r_ovf <= r_ovf || (|w_lost);
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through event FIFO
    // ------------------------------------------------------------------
    assign w_empty = r_wr_ptr == r_rd_ptr;
    assign w_full  = (r_wr_ptr ^ r_rd_ptr) == c_full_pat;
    assign w_pop   = !w_empty && evt_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= {w_sel, w_sel_k};
        end
    end

    assign w_head      = r_mem[r_rd_ptr[c_aw-1:0]];
    assign evt_valid_o = !w_empty;
    assign evt_btn_o   = evt_valid_o ? w_head[IDX_W+1:2] : '0;
    assign evt_kind_o  = evt_valid_o ? w_head[1:0] : 2'd0;
    assign state_o     = r_state;
    assign overflow_o  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_capsense_event.sv
`default_nettype none
// ============================================================================
// Module   : tb_capsense_event
// Brief    : Self-checking bench for capsense_event against a behavioural
//            model; honours CAPSENSE_EVT_LONGPRESS_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capsense_event;

    localparam int N     = 4;
    localparam int DEB   = 3;
    localparam int LT    = 5;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_stb;
    logic [3:0] buttons;
    logic       tick;
    logic       ready;
    logic [3:0] state;
    logic       evt_valid;
    logic [1:0] evt_btn;
    logic [1:0] evt_kind;
    logic       ovf;

    capsense_event #(
        .N(N), .DEBOUNCE(DEB), .LONG_TICKS(LT), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .sample_stb_i(sample_stb), .buttons_i(buttons),
        .tick_i(tick), .state_o(state), .evt_valid_o(evt_valid),
        .evt_ready_i(ready), .evt_btn_o(evt_btn), .evt_kind_o(evt_kind),
        .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-button agreement counting, held-tick count,
    // one pending slot per button, and a queue standing in for the FIFO.
    logic [3:0] m_st;
    logic [3:0] m_pv;
    int         m_dc   [N];
    int         m_held [N];
    int         m_pk   [N];
    int         m_qb   [$];
    int         m_qk   [$];
    logic       m_ovf;
    logic       m_live = 1'b0;

    logic       mp_pop, mp_push, mp_long;
    int         mp_sel, mp_pb, mp_pk;
    logic [3:0] mp_flip, mp_nv;
    int         mp_nk [N];

    always @(posedge clk) begin
        if (rst) begin
            m_st = '0; m_pv = '0; m_ovf = 1'b0; m_live = 1'b1;
            for (int i = 0; i < N; i++) begin
                m_dc[i] = 0; m_held[i] = 0; m_pk[i] = 0;
            end
            m_qb.delete(); m_qk.delete();
        end else begin
            mp_pop = (m_qb.size() > 0) && ready;
            mp_sel = -1;
            for (int i = 0; i < N; i++) if (m_pv[i] && mp_sel < 0) mp_sel = i;
            mp_push = (mp_sel >= 0) && ((m_qb.size() < DEPTH) || mp_pop);
            mp_pb = 0; mp_pk = 0;
            if (mp_push) begin mp_pb = mp_sel; mp_pk = m_pk[mp_sel]; end
            for (int i = 0; i < N; i++) begin
                mp_nv[i] = 1'b0; mp_nk[i] = 0; mp_flip[i] = 1'b0;
                if (sample_stb) begin
                    if (buttons[i] != m_st[i]) begin
                        m_dc[i]++;
                        if (m_dc[i] == DEB) begin
                            m_dc[i] = 0; mp_flip[i] = 1'b1; mp_nv[i] = 1'b1;
                            mp_nk[i] = m_st[i] ? 0 : 1;
                        end
                    end else begin
                        m_dc[i] = 0;
                    end
                end
`ifdef CAPSENSE_EVT_LONGPRESS_EN
                mp_long = 1'b0;
                if (m_st[i] && tick) begin
                    m_held[i]++;
                    if (m_held[i] == LT) mp_long = 1'b1;
                end
                if (mp_flip[i]) begin
                    m_held[i] = 0;
                    if (mp_long) m_ovf = 1'b1;
                end else if (mp_long) begin
                    mp_nv[i] = 1'b1; mp_nk[i] = 2;
                end
`endif
                if (mp_nv[i]) begin
                    if (m_pv[i] && !(mp_push && mp_sel == i)) m_ovf = 1'b1;
                    m_pv[i] = 1'b1; m_pk[i] = mp_nk[i];
                end else if (mp_push && mp_sel == i) begin
                    m_pv[i] = 1'b0;
                end
                if (mp_flip[i]) m_st[i] = ~m_st[i];
            end
            if (mp_pop) begin void'(m_qb.pop_front()); void'(m_qk.pop_front()); end
            if (mp_push) begin m_qb.push_back(mp_pb); m_qk.push_back(mp_pk); end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("state_o", state, m_st);
            check("evt_valid_o", evt_valid, m_qb.size() > 0);
            check("evt_btn_o", evt_btn, (m_qb.size() > 0) ? m_qb[0] : 0);
            check("evt_kind_o", evt_kind, (m_qk.size() > 0) ? m_qk[0] : 0);
            check("overflow_o", ovf, m_ovf);
        end
    end

    // Log of accepted events, for the literal scenario checks.
    int lg_b [$];
    int lg_k [$];
    int lg_c [$];
    int cyc = 0;
    always @(posedge clk) begin
        if (!rst && evt_valid && ready) begin
            lg_b.push_back(evt_btn); lg_k.push_back(evt_kind); lg_c.push_back(cyc);
        end
        cyc++;
    end

    task automatic clear_log();
        lg_b.delete(); lg_k.delete(); lg_c.delete();
    endtask

    task automatic step(input logic s, input logic [3:0] b, input logic t, input logic r);
        sample_stb = s; buttons = b; tick = t; ready = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; sample_stb = 1'b0; tick = 1'b0; ready = 1'b0; buttons = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] intent, glitch;
    int         k2;

    initial begin
        rst = 1'b1; sample_stb = 1'b0; buttons = '0; tick = 1'b0; ready = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_state", state, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_ovf", ovf, 0);

        // Debounce flip and 2-cycle latency
        step(1, 4'b0001, 0, 0); step(0, 4'b0001, 0, 0);
        step(1, 4'b0001, 0, 0);
        check("t1_state_strobe2", state, 4'b0000);
        step(0, 4'b0001, 0, 0);
        step(1, 4'b0001, 0, 0);
        check("t1_state_strobe3", state, 4'b0001);
        check("t1_valid_t1", evt_valid, 0);
        step(0, 4'b0001, 0, 0);
        check("t1_valid_t2", evt_valid, 1);
        check("t1_btn", evt_btn, 0);
        check("t1_kind", evt_kind, 1);

        // Glitch rejection
        do_reset();
        step(1, 4'b0001, 0, 0); step(1, 4'b0000, 0, 0);
        step(1, 4'b0001, 0, 0); step(1, 4'b0001, 0, 0);
        repeat (4) step(0, 4'b0001, 0, 0);
        check("t2_state", state, 0);
        check("t2_valid", evt_valid, 0);

        // Simultaneous flips drain in index order on consecutive cycles
        do_reset(); clear_log();
        repeat (3) step(1, 4'b1011, 0, 1);
        repeat (6) step(0, 4'b1011, 0, 1);
        check("t3_count", lg_b.size(), 3);
        if (lg_b.size() == 3) begin
            check("t3_btn0", lg_b[0], 0); check("t3_btn1", lg_b[1], 1);
            check("t3_btn2", lg_b[2], 3);
            check("t3_kinds", {lg_k[0][1:0], lg_k[1][1:0], lg_k[2][1:0]}, 6'b010101);
            check("t3_gap01", lg_c[1] - lg_c[0], 1);
            check("t3_gap12", lg_c[2] - lg_c[1], 1);
        end

        // Backpressure and overflow on button 2
        do_reset(); clear_log();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) check("t4_ovf_before", ovf, 0);
            repeat (3) step(1, (k % 2 == 0) ? 4'b0100 : 4'b0000, 0, 0);
            repeat (2) step(0, (k % 2 == 0) ? 4'b0100 : 4'b0000, 0, 0);
        end
        check("t4_ovf_after", ovf, 1);
        check("t4_head_btn", evt_btn, 2);
        check("t4_head_kind", evt_kind, 1);
        repeat (10) step(0, 4'b0000, 0, 1);
        check("t4_count", lg_b.size(), 5);
        if (lg_b.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                check("t4_btn", lg_b[k], 2);
                check("t4_kind", lg_k[k], (k == 1 || k >= 3) ? 0 : 1);
            end
        end

        // Long press on button 1
        do_reset(); clear_log();
        repeat (3) step(1, 4'b0010, 0, 1);
        for (int t = 0; t < 7; t++) begin
            step(0, 4'b0010, 1, 1);
            repeat (2) step(0, 4'b0010, 0, 1);
        end
        repeat (3) step(1, 4'b0000, 0, 1);
        repeat (5) step(0, 4'b0000, 0, 1);
        k2 = 0;
        foreach (lg_k[k]) if (lg_k[k] == 2) k2++;
`ifdef CAPSENSE_EVT_LONGPRESS_EN
        check("t5_count", lg_b.size(), 3);
        check("t5_long_count", k2, 1);
        if (lg_b.size() == 3) begin
            check("t5_kinds", {lg_k[0][1:0], lg_k[1][1:0], lg_k[2][1:0]}, 6'b011000);
            check("t5_btns", {lg_b[0][1:0], lg_b[1][1:0], lg_b[2][1:0]}, 6'b010101);
        end
`else
        check("t5_count", lg_b.size(), 2);
        check("t5_long_count", k2, 0);
        if (lg_b.size() == 2) begin
            check("t5_kinds", {lg_k[0][1:0], lg_k[1][1:0]}, 4'b0100);
        end
`endif

        // Reset mid-run with queued events
        do_reset();
        repeat (3) step(1, 4'b0111, 0, 0);
        repeat (4) step(0, 4'b0111, 0, 0);
        check("t6_valid_before", evt_valid, 1);
        check("t6_state_before", state, 4'b0111);
        rst = 1'b1;
        step(0, 4'b0111, 0, 0);
        rst = 1'b0;
        check("t6_valid", evt_valid, 0);
        check("t6_state", state, 0);
        check("t6_ovf", ovf, 0);
        step(0, 4'b0111, 0, 1);
        check("t6_valid_later", evt_valid, 0);

        // Randomised traffic against the model
        do_reset();
        intent = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) do_reset();
            if ($urandom_range(0, 7) == 0) intent[$urandom_range(0, N - 1)] ^= 1'b1;
            for (int b = 0; b < N; b++) glitch[b] = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 2) == 0, intent ^ glitch, $urandom_range(0, 3) == 0,
                 ((i / 200) % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
